// File: rtl/map_port_arbiter.sv
// ============================================================================
// Module : map_port_arbiter
// Desc   : Arbitrates port B of bRAM_map among N_REQ valid/ready requesters and
//          routes read data back. Optional macro MAP_ARB_FIXED_PRIO_EN selects
//          fixed priority instead of round-robin.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module map_port_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAP_DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic                    bram_we,
  output logic [DATA_W-1:0]       bram_din,
  input  logic [DATA_W-1:0]       bram_dout,
  output logic                    err_oor
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] C_DEPTH = ADDR_W'(MAP_DEPTH);

  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic              w_accept;
  logic              w_we;
  logic              w_oor;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [N_REQ-1:0]  w_rsp_onehot;

  // Tag pipeline: stage k holds the read accepted k edges ago.
  logic [RD_LAT:0]             r_tag_vld;
  logic [RD_LAT:0]             r_tag_oor;
  logic [RD_LAT:0][IDX_W-1:0]  r_tag_idx;

`ifdef MAP_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_grant    = '0;
        w_grant[k] = 1'b1;
        w_gidx     = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] r_last;
  logic             w_found;
  int               w_pos;

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = int'(r_last) + 1 + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      if (!w_found && req_valid[w_pos]) begin
        w_found        = 1'b1;
        w_grant[w_pos] = 1'b1;
        w_gidx         = IDX_W'(w_pos);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_last <= IDX_W'(N_REQ - 1);
    else if (w_accept) r_last <= w_gidx;
  end
`endif

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_wdata = req_wdata[i*DATA_W +: DATA_W];
        w_we    = req_we[i];
      end
    end
  end

  assign w_accept  = |w_grant;
  assign w_oor     = (w_addr >= C_DEPTH);
  assign req_ready = w_grant;

  always_comb begin
    w_rsp_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rsp_onehot[i] = (r_tag_idx[RD_LAT] == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bram_addr <= '0;
      bram_we   <= 1'b0;
      bram_din  <= '0;
      err_oor   <= 1'b0;
      r_tag_vld <= '0;
      r_tag_oor <= '0;
      r_tag_idx <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      // Out-of-range writes are swallowed; out-of-range reads answer zero.
      bram_we <= w_accept & w_we & ~w_oor;
      if (w_accept) begin
        bram_addr <= w_addr;
        bram_din  <= w_wdata;
        if (w_oor) err_oor <= 1'b1;
      end
      r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_accept & ~w_we};
      r_tag_oor <= {r_tag_oor[RD_LAT-1:0], w_oor};
      r_tag_idx <= {r_tag_idx[RD_LAT-1:0], w_gidx};
      rsp_valid <= r_tag_vld[RD_LAT] ? w_rsp_onehot : '0;
      if (r_tag_vld[RD_LAT]) rsp_data <= r_tag_oor[RD_LAT] ? '0 : bram_dout;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_map_port_arbiter.sv
// ============================================================================
// Module : tb_map_port_arbiter
// Desc   : Directed scoreboard bench for map_port_arbiter with a RAM model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_map_port_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_we = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*DATA_W-1:0] req_wdata = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic [ADDR_W-1:0]       bram_addr;
  logic                    bram_we;
  logic [DATA_W-1:0]       bram_din;
  logic [DATA_W-1:0]       bram_dout = '0;
  logic                    err_oor;

  map_port_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .MAP_DEPTH(256)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
    .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  // Read-first single-port RAM, one clock read latency.
  logic [DATA_W-1:0] mem [0:511];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr[8:0]] <= bram_din;
    bram_dout <= mem[bram_addr[8:0]];
  end

  typedef struct {
    logic [N_REQ-1:0]  onehot;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every response strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b, required none", rsp_valid);
      end else begin
        e = q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Presents one request (others idle), checks the grant and queues the read response.
  task automatic drive(input int idx, input bit we, input int addr, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] rd_exp, input bit track);
    exp_t x;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_we[idx] = we;
    req_addr[idx*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    req_wdata[idx*DATA_W +: DATA_W] = wd;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(1 << idx));
    if (!we && track) begin
      x.onehot = N_REQ'(1 << idx);
      x.data   = rd_exp;
      x.cyc    = cyc + 3;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_vals;
    check("rst_bram_addr", 32'(bram_addr), 32'd0);
    check("rst_bram_we", 32'(bram_we), 32'd0);
    check("rst_bram_din", 32'(bram_din), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_err_oor", 32'(err_oor), 32'd0);
  endtask

  logic [N_REQ-1:0] order_exp [0:8];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'h0004;
    mem[5] = 16'h0012; mem[10] = 16'h5555; mem[300] = 16'hBEEF;
`ifdef MAP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 9; i++) order_exp[i] = 3'b001;
`else
    for (int i = 0; i < 9; i++) order_exp[i] = 3'b001 << (i % 3);
`endif

    // Reset state, and grant follows valid during reset.
    repeat (2) @(negedge clk);
    check_reset_vals();
    req_valid = 3'b100;
    #1;
    check("ready_in_reset", 32'(req_ready), 32'b100);
    req_valid = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // All three requesting continuously: writes to scratch addresses.
    req_we = 3'b111;
    req_addr = {ADDR_W'(202), ADDR_W'(201), ADDR_W'(200)};
    req_wdata = {16'h2222, 16'h1111, 16'h0000};
    req_valid = 3'b111;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(order_exp[k]));
      @(posedge clk); #1;
    end
    idle_cycles(1);
    req_we = '0;

    // Single read by requester 1 from address 5.
    drive(1, 1'b0, 5, 16'h0, 16'h0012, 1'b1);
    idle_cycles(4);
    drain();

    // Write then read-after-write on the next cycle.
    drive(2, 1'b1, 10, 16'h00A7, 16'h0, 1'b1);
    check("wr_bram_we", 32'(bram_we), 32'd1);
    check("wr_bram_addr", 32'(bram_addr), 32'd10);
    check("wr_bram_din", 32'(bram_din), 32'h00A7);
    drive(0, 1'b0, 10, 16'h0, 16'h00A7, 1'b1);
    idle_cycles(4);
    drain();

    // Out-of-range write and read.
    check("oor_before", 32'(err_oor), 32'd0);
    drive(0, 1'b1, 300, 16'h1234, 16'h0, 1'b1);
    check("oor_bram_we", 32'(bram_we), 32'd0);
    check("oor_flag", 32'(err_oor), 32'd1);
    idle_cycles(2);
    drive(0, 1'b0, 300, 16'h0, 16'h0000, 1'b1);
    idle_cycles(4);
    drain();
    check("oor_sticky", 32'(err_oor), 32'd1);

    // Back-to-back reads to requester 1.
    for (int a = 0; a < 4; a++) drive(1, 1'b0, a, 16'h0, DATA_W'(a + 1), 1'b1);
    idle_cycles(5);
    drain();

    // Reads in flight, then reset: none of them may respond.
    drive(0, 1'b0, 0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 1, 16'h0, 16'h0, 1'b0);
    drive(2, 1'b0, 2, 16'h0, 16'h0, 1'b0);
    req_valid = '0;
    rstn = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rstn = 1'b1;
    idle_cycles(6);
    check_reset_vals();
    check("final_queue", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
